ks_add_sched: RTL and testbench

KS_ADD_SCHED -- requirements
Module: ks_add_sched

---
 rtl/ks_add_sched.sv | 164 ++++++++++++++++
 tb/tb_ks_add_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_add_sched.sv
// Round-robin scheduler feeding a shared, pipelined 16-bit Kogge-Stone adder.
// A chained beat locks the adder so the requester can finish a 32-bit add.
module ks_add_sched #(
    parameter int N_REQ = 4,
    parameter int LAT   = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_req_valid,
    input  logic [16*N_REQ-1:0]   i_req_a,
    input  logic [16*N_REQ-1:0]   i_req_b,
    input  logic [N_REQ-1:0]      i_req_cin,
    input  logic [N_REQ-1:0]      i_req_chain,
    output logic [N_REQ-1:0]      o_req_ready,
    output logic                  o_res_valid,
    output logic [1:0]            o_res_id,
    output logic [15:0]           o_sum,
    output logic                  o_cout,
    input  logic                  i_res_ready,
    output logic                  o_busy
);
    typedef enum logic [1:0] {ARB, LOCK, HIGH} state_t;
    localparam int CW = $clog2(LAT + 1);

    function automatic logic [15:0] ks_g(input logic [15:0] g,
                                         input logic [15:0] p,
                                         input int d);
        logic [15:0] r;
        r = g;
        for (int i = d; i < 16; i++) r[i] = g[i] | (p[i] & g[i-d]);
        return r;
    endfunction

    function automatic logic [15:0] ks_p(input logic [15:0] p,
                                         input int d);
        logic [15:0] r;
        r = p;
        for (int i = d; i < 16; i++) r[i] = p[i] & p[i-d];
        return r;
    endfunction

    state_t         state;
    logic [1:0]     rr_ptr;
    logic [1:0]     lock_id;
    logic [CW-1:0]  cnt;
    logic           carry_hold;
    logic           rst_q;

    logic           v0, v1, v2, res_v;
    logic [1:0]     id0, id1, id2, res_id;
    logic [15:0]    g0, p0, x0, g1, p1, x1, g2, x2;
    logic           c0, c1, c2;
    logic [15:0]    res_sum;
    logic           res_cout;

    logic [N_REQ-1:0] grant;
    logic [1:0]     gidx;
    logic [1:0]     idx;
    logic           accept;
    logic           stall;
    logic [15:0]    a_sel, b_sel;
    logic           cin_sel;
    logic [15:0]    pg_p, pg_g;
    logic [15:0]    l1_g, l1_p, l2_g, l2_p, l3_g, l3_p, l4_g;

    assign stall = o_res_valid & ~i_res_ready;

    always_comb begin
        grant = '0;
        idx   = '0;
        if (!(i_rst || rst_q || stall)) begin
            unique case (state)
                ARB: begin
                    for (int k = 1; k <= N_REQ; k++) begin
                        idx = rr_ptr + 2'(k);
                        if (i_req_valid[idx] && grant == '0)
                            grant[idx] = 1'b1;
                    end
                end
                LOCK: grant = '0;
                HIGH: grant[lock_id] = i_req_valid[lock_id];
                default: grant = '0;
            endcase
        end
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant[i]) gidx = 2'(i);
    end

    assign accept  = |grant;
    assign a_sel   = i_req_a[16*gidx +: 16];
    assign b_sel   = i_req_b[16*gidx +: 16];
    assign cin_sel = (state == HIGH) ? carry_hold : i_req_cin[gidx];

    // Carry-in is folded into bit 0 generate so the prefix tree yields carries.
    assign pg_p = a_sel ^ b_sel;
    assign pg_g = (a_sel & b_sel) | {15'd0, pg_p[0] & cin_sel};

    assign l1_g = ks_g(g0, p0, 1);
    assign l1_p = ks_p(p0, 1);
    assign l2_g = ks_g(l1_g, l1_p, 2);
    assign l2_p = ks_p(l1_p, 2);
    assign l3_g = ks_g(g1, p1, 4);
    assign l3_p = ks_p(p1, 4);
    assign l4_g = ks_g(l3_g, l3_p, 8);

    always_ff @(posedge i_clk) begin
        rst_q <= i_rst;
        if (i_rst) begin
            state      <= ARB;
            rr_ptr     <= 2'd3;
            lock_id    <= '0;
            cnt        <= '0;
            carry_hold <= 1'b0;
            v0 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0; res_v <= 1'b0;
            id0 <= '0; id1 <= '0; id2 <= '0; res_id <= '0;
            g0 <= '0; p0 <= '0; x0 <= '0; c0 <= 1'b0;
            g1 <= '0; p1 <= '0; x1 <= '0; c1 <= 1'b0;
            g2 <= '0; x2 <= '0; c2 <= 1'b0;
            res_sum  <= '0;
            res_cout <= 1'b0;
        end else if (!stall) begin
            v0 <= accept; id0 <= gidx;
            g0 <= pg_g; p0 <= pg_p; x0 <= pg_p; c0 <= cin_sel;
            v1 <= v0; id1 <= id0;
            g1 <= l2_g; p1 <= l2_p; x1 <= x0; c1 <= c0;
            v2 <= v1; id2 <= id1;
            g2 <= l4_g; x2 <= x1; c2 <= c1;
            res_v    <= v2;
            res_id   <= id2;
            res_sum  <= x2 ^ {g2[14:0], c2};
            res_cout <= g2[15];
            if (accept) rr_ptr <= gidx;
            unique case (state)
                ARB: begin
                    if (accept && i_req_chain[gidx]) begin
                        state   <= LOCK;
                        lock_id <= gidx;
                        cnt     <= CW'(LAT);
                    end
                end
                LOCK: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    if (res_v && res_id == lock_id && cnt == '0) begin
                        carry_hold <= res_cout;
                        state      <= HIGH;
                    end
                end
                HIGH: if (accept) state <= ARB;
                default: state <= ARB;
            endcase
        end
    end

    assign o_req_ready = grant;
    assign o_res_valid = res_v & ~i_rst;
    assign o_res_id    = i_rst ? 2'd0 : res_id;
    assign o_sum       = i_rst ? 16'd0 : res_sum;
    assign o_cout      = res_cout & ~i_rst;
    assign o_busy      = ~i_rst & (v0 | v1 | v2 | res_v | (state != ARB));
endmodule

// File: tb/tb_ks_add_sched.sv
// Randomised scoreboard bench for ks_add_sched.
// Reference tracks arbitration/lock at transaction level, sums by plain arithmetic.
module tb_ks_add_sched;
    localparam int M_ARB = 0, M_LOCK = 1, M_HIGH = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_rst;
    logic [3:0]  i_req_valid;
    logic [63:0] i_req_a, i_req_b;
    logic [3:0]  i_req_cin, i_req_chain;
    logic [3:0]  o_req_ready;
    logic        o_res_valid;
    logic [1:0]  o_res_id;
    logic [15:0] o_sum;
    logic        o_cout;
    logic        i_res_ready;
    logic        o_busy;

    ks_add_sched #(.N_REQ(4), .LAT(3)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .i_req_a(i_req_a), .i_req_b(i_req_b),
        .i_req_cin(i_req_cin), .i_req_chain(i_req_chain),
        .o_req_ready(o_req_ready), .o_res_valid(o_res_valid),
        .o_res_id(o_res_id), .o_sum(o_sum), .o_cout(o_cout),
        .i_res_ready(i_res_ready), .o_busy(o_busy)
    );

    typedef struct {
        logic [15:0] a, b;
        logic        cin, chain;
    } beat_t;
    typedef struct {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        cout, low;
    } exp_t;

    beat_t stim [4][$];
    exp_t  sb[$];

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int low_cyc = -1;
    int lock_cyc = 0;
    int mode = M_ARB;
    int rr = 3;
    int lock_id = 0;
    logic carry_low = 1'b0;
    logic [3:0] dl = '0;
    logic [3:0] acc_mask = '0;
    logic rst_prev = 1'b0;
    logic stall_hold = 1'b0, rand_rdy = 1'b0;

    always @(posedge clk) cyc++;

    // Driver: retire accepted beats, present queue heads.
    always @(posedge clk) begin
        #1;
        for (int r = 0; r < 4; r++) begin
            if (acc_mask[r] && stim[r].size() > 0) void'(stim[r].pop_front());
            if (stim[r].size() > 0) begin
                i_req_valid[r] = 1'b1;
                i_req_a[16*r +: 16] = stim[r][0].a;
                i_req_b[16*r +: 16] = stim[r][0].b;
                i_req_cin[r] = stim[r][0].cin;
                i_req_chain[r] = stim[r][0].chain;
            end else begin
                i_req_valid[r] = 1'b0;
                i_req_chain[r] = 1'b0;
            end
        end
        i_res_ready = stall_hold ? 1'b0 :
                      rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Reference model: expected grants, output occupancy and busy.
    logic [3:0]  exp_g;
    logic        stall;
    logic [16:0] full;
    int          gi, ix;
    exp_t        e;
    always @(negedge clk) begin
        if (i_rst) begin
            n_tests++;
            if (o_req_ready != 0 || o_res_valid || o_res_id != 0 ||
                o_sum != 0 || o_cout || o_busy) begin
                n_fail++;
                $display("FAIL reset_outs: got rdy=%b v=%b id=%0d sum=%h c=%b busy=%b want all 0",
                         o_req_ready, o_res_valid, o_res_id, o_sum, o_cout, o_busy);
            end
            mode = M_ARB; rr = 3; dl = '0; acc_mask = '0;
            sb.delete();
            rst_prev = 1'b1;
        end else begin
            if (rst_prev) begin
                n_tests++;
                if (o_res_id != 0 || o_sum != 0 || o_cout) begin
                    n_fail++;
                    $display("FAIL post_reset_data: got id=%0d sum=%h c=%b want 0",
                             o_res_id, o_sum, o_cout);
                end
            end
            if (mode == M_LOCK && low_cyc > lock_cyc && cyc > low_cyc)
                mode = M_HIGH;
            stall = dl[3] && !i_res_ready;
            exp_g = '0;
            if (!rst_prev && !stall) begin
                if (mode == M_ARB) begin
                    for (int k = 1; k <= 4; k++) begin
                        ix = (rr + k) % 4;
                        if (i_req_valid[ix] && exp_g == 0) exp_g[ix] = 1'b1;
                    end
                end else if (mode == M_HIGH) begin
                    exp_g[lock_id] = i_req_valid[lock_id];
                end
            end
            n_tests++;
            if (o_req_ready !== exp_g) begin
                n_fail++;
                $display("FAIL grant: got %b want %b (cyc %0d)", o_req_ready, exp_g, cyc);
            end
            n_tests++;
            if (o_res_valid !== dl[3]) begin
                n_fail++;
                $display("FAIL res_valid: got %b want %b (cyc %0d)", o_res_valid, dl[3], cyc);
            end
            n_tests++;
            if (o_busy !== (dl != 0 || mode != M_ARB)) begin
                n_fail++;
                $display("FAIL busy: got %b want %b (cyc %0d)", o_busy,
                         (dl != 0 || mode != M_ARB), cyc);
            end
            acc_mask = exp_g;
            if (exp_g != 0) begin
                gi = 0;
                for (int r = 0; r < 4; r++) if (exp_g[r]) gi = r;
                full = 17'(i_req_a[16*gi +: 16]) + 17'(i_req_b[16*gi +: 16]) +
                       17'((mode == M_HIGH) ? carry_low : i_req_cin[gi]);
                e.id = 2'(gi);
                e.sum = full[15:0];
                e.cout = full[16];
                e.low = (mode == M_ARB) && i_req_chain[gi];
                sb.push_back(e);
                if (e.low) begin
                    mode = M_LOCK; lock_id = gi; lock_cyc = cyc; carry_low = full[16];
                end else if (mode == M_HIGH) begin
                    mode = M_ARB;
                end
                rr = gi;
            end
            if (!stall) dl = {dl[2:0], exp_g != 0};
            rst_prev = 1'b0;
        end
    end

    // Monitor: pop and compare each delivered result.
    exp_t m;
    always @(negedge clk) begin
        if (!i_rst && o_res_valid && i_res_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL result_extra: got id=%0d sum=%h with nothing expected",
                         o_res_id, o_sum);
            end else begin
                m = sb.pop_front();
                if (o_res_id !== m.id || o_sum !== m.sum || o_cout !== m.cout) begin
                    n_fail++;
                    $display("FAIL result: got id=%0d sum=%h c=%b want id=%0d sum=%h c=%b",
                             o_res_id, o_sum, o_cout, m.id, m.sum, m.cout);
                end
                if (m.low) low_cyc = cyc;
            end
        end
    end

    task automatic add(input int r, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic chain);
        beat_t bt;
        bt.a = a; bt.b = b; bt.cin = cin; bt.chain = chain;
        stim[r].push_back(bt);
    endtask

    function automatic bit pending();
        bit p;
        p = (sb.size() != 0) || (dl != 0) || (mode != M_ARB);
        for (int r = 0; r < 4; r++) if (stim[r].size() != 0) p = 1;
        return p;
    endfunction

    task automatic drain(input string name);
        int t;
        t = 0;
        while (pending() && t < 3000) begin
            @(posedge clk); #2; t++;
        end
        n_tests++;
        if (t >= 3000) begin
            n_fail++;
            $display("FAIL drain_%s: got still busy after %0d cycles want idle", name, t);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #2;
        i_rst = 1'b1;
        for (int r = 0; r < 4; r++) stim[r].delete();
        repeat (n) @(posedge clk);
        #2 i_rst = 1'b0;
    endtask

    int r, t;
    bit c;
    initial begin
        i_rst = 1'b1;
        i_req_valid = '0; i_req_a = '0; i_req_b = '0;
        i_req_cin = '0; i_req_chain = '0; i_res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 i_rst = 1'b0;
        repeat (2) @(posedge clk);

        add(1, 16'h1234, 16'h0FF0, 1'b0, 1'b0);
        drain("single");
        add(0, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
        drain("overflow");

        do_reset(2);
        for (int i = 0; i < 6; i++)
            for (int q = 0; q < 4; q++)
                add(q, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        drain("fair");

        add(2, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        add(2, 16'h0000, 16'h0000, 1'b0, 1'b0);
        add(0, 16'h0101, 16'h0202, 1'b0, 1'b0);
        add(3, 16'h8000, 16'h8000, 1'b0, 1'b0);
        drain("chain");

        for (int i = 0; i < 3; i++)
            for (int q = 0; q < 4; q++)
                add(q, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        repeat (4) @(posedge clk);
        #2 stall_hold = 1'b1;
        repeat (5) @(posedge clk);
        #2 stall_hold = 1'b0;
        drain("stall");

        rand_rdy = 1'b1;
        repeat (400) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 3);
                if (stim[r].size() < 4) begin
                    c = ($urandom_range(0, 7) == 0);
                    add(r, 16'($urandom), 16'($urandom), 1'($urandom), c);
                    if (c) add(r, 16'($urandom), 16'($urandom), 1'($urandom),
                               1'($urandom));
                end
            end
        end
        rand_rdy = 1'b0;
        drain("random");

        add(3, 16'h0003, 16'h0004, 1'b0, 1'b0);
        add(0, 16'h0005, 16'h0006, 1'b0, 1'b0);
        add(1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        add(1, 16'h0001, 16'h0001, 1'b0, 1'b0);
        t = 0;
        while (mode != M_LOCK && t < 50) begin
            @(posedge clk); #2; t++;
        end
        n_tests++;
        if (t >= 50) begin
            n_fail++;
            $display("FAIL lock_wait: got mode %0d want LOCK", mode);
        end
        do_reset(1);
        repeat (6) @(posedge clk);
        for (int q = 0; q < 4; q++)
            add(q, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
        drain("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
